// File: rtl/vga_sync_gen_if.sv
// Coordinate bus between the video timing generator and the graphics block.
// The generator publishes the scan position; the graphics block answers with a colour.
interface vga_sync_gen_if;
  logic       pixel_tick;
  logic [9:0] coord_x;
  logic [9:0] coord_y;
  logic       active_area;
  logic       line_start;
  logic       frame_start;
  logic [2:0] rgb_in;

  // No handshake: the graphics block simply follows the coord bus and must
  // present rgb_in before the end of the pixel period that shows its coord.
  modport master (
    output pixel_tick, coord_x, coord_y, active_area, line_start, frame_start,
    input  rgb_in
  );

  modport slave (
    input  pixel_tick, coord_x, coord_y, active_area, line_start, frame_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate divider, h/v scan counters, coord bus
// (stage A) and registered rgb/sync outputs one pixel period later (stage B).
module vga_sync_gen #(
  parameter int CLK_DIV         = 4,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  vga_sync_gen_if.master   bus,
  output logic             hsync,
  output logic             vsync,
  output logic [2:0]       rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;

  logic [9:0]       x_q, y_q;
  logic             act_q, act_d;
  logic             hs_raw_q, hs_raw_d;
  logic             vs_raw_q, vs_raw_d;
  logic             ls_q, fs_q;

  logic             hsync_q, vsync_q;
  logic [2:0]       rgb_q;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    // Stage A decodes the post-advance position so it lands with the new coord.
    act_d    = ({1'b0, h_d} < H_ACT_END) && ({1'b0, v_d} < V_ACT_END);
    hs_raw_d = ({1'b0, h_d} >= H_SYNC_BEG) && ({1'b0, h_d} < H_SYNC_END);
    vs_raw_d = ({1'b0, v_d} >= V_SYNC_BEG) && ({1'b0, v_d} < V_SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      h_q      <= H_LAST;
      v_q      <= V_LAST;
      x_q      <= '0;
      y_q      <= '0;
      act_q    <= 1'b0;
      hs_raw_q <= 1'b0;
      vs_raw_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      hsync_q  <= SYNC_IDLE;
      vsync_q  <= SYNC_IDLE;
      rgb_q    <= 3'b000;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      // Pulses are rewritten every clk so they stay one clk wide at any divide.
      ls_q  <= tick && (h_d == '0);
      fs_q  <= tick && (h_d == '0) && (v_d == '0);
      if (tick) begin
        x_q      <= h_d;
        y_q      <= v_d;
        act_q    <= act_d;
        hs_raw_q <= hs_raw_d;
        vs_raw_q <= vs_raw_d;
        rgb_q    <= act_q ? bus.rgb_in : 3'b000;
        hsync_q  <= hs_raw_q ^ SYNC_IDLE;
        vsync_q  <= vs_raw_q ^ SYNC_IDLE;
      end
    end
  end

  assign bus.pixel_tick  = tick;
  assign bus.coord_x     = x_q;
  assign bus.coord_y     = y_q;
  assign bus.active_area = act_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances (divide-by-4 active-low, divide-by-1 active-high)
// with short vertical timing, checked each cycle against a closed-form raster model.
module tb_vga_sync_gen;

  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48, HT = 800;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1, VT = 8;

  localparam int   CDV  [2] = '{4, 1};
  localparam logic SALV [2] = '{1'b1, 1'b0};

  localparam int FRAME_LEN [2] = '{25600, 6400};
  localparam int LINE_LEN  [2] = '{3200, 800};
  localparam int HS_LEN    [2] = '{384, 96};
  localparam int VS_LEN    [2] = '{6400, 1600};
  localparam int FIRST_FS  [2] = '{5, 2};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_gen_if bus_a ();
  vga_sync_gen_if bus_b ();
  logic       hs_a, vs_a, hs_b, vs_b;
  logic [2:0] rgb_a, rgb_b;

  vga_sync_gen #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a), .hsync(hs_a), .vsync(vs_a), .rgb_out(rgb_a)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b), .hsync(hs_b), .vsync(vs_b), .rgb_out(rgb_b)
  );

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [2:0] rgb;
  } obs_t;

  int errors = 0;
  int checks = 0;
  int fail_prints = 0;

  // Reference: c = clocks since the last reset edge (1 = first cycle after it).
  // Tick edges seen so far = (c-1)/cd; the n-th edge shows raster pixel n-1 on the
  // coord bus and pixel n-2 (with the colour captured at that edge) on rgb/sync.
  function automatic obs_t model(input int c, input int cd, input logic sal,
                                 input logic [2:0] cap);
    obs_t e;
    int p, pix, h, v, hq, vq;
    e = '0;
    e.hs = sal;
    e.vs = sal;
    p = (c - 1) / cd;
    e.tick = ((c % cd) == 0);
    if (p >= 1) begin
      pix   = p - 1;
      h     = pix % HT;
      v     = (pix / HT) % VT;
      e.x   = 10'(h);
      e.y   = 10'(v);
      e.act = (h < HA) && (v < VA);
      e.ls  = (h == 0) && (((c - 1) % cd) == 0);
      e.fs  = e.ls && (v == 0);
    end
    if (p >= 2) begin
      pix   = p - 2;
      hq    = pix % HT;
      vq    = (pix / HT) % VT;
      e.hs  = ((hq >= HA + HFP) && (hq < HA + HFP + HS)) ? ~sal : sal;
      e.vs  = ((vq >= VA + VFP) && (vq < VA + VFP + VS)) ? ~sal : sal;
      e.rgb = ((hq < HA) && (vq < VA)) ? cap : 3'b000;
    end
    return e;
  endfunction

  task automatic check_int(input string name, input int d, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, d, got, exp);
    end
  endtask

  task automatic check_obs(input int d, input int c, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL outputs dut%0d cyc=%0d: got tick=%0b x=%0d y=%0d act=%0b ls=%0b fs=%0b hs=%0b vs=%0b rgb=%0d expected tick=%0b x=%0d y=%0d act=%0b ls=%0b fs=%0b hs=%0b vs=%0b rgb=%0d",
                 d, c, got.tick, got.x, got.y, got.act, got.ls, got.fs, got.hs, got.vs, got.rgb,
                 exp.tick, exp.x, exp.y, exp.act, exp.ls, exp.fs, exp.hs, exp.vs, exp.rgb);
      end
    end
  endtask

  // driver: fresh random colour every clock, changing mid pixel period
  initial begin
    bus_a.rgb_in = 3'b000;
    bus_b.rgb_in = 3'b000;
    forever begin
      @(posedge clk);
      #2;
      bus_a.rgb_in = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      bus_b.rgb_in = 3'($urandom_range(0, 7));
    end
  end

  // scoreboard / compare process
  int         cyc [2];
  int         abs_cyc = 0;
  bit         started = 1'b0;
  logic [2:0] cap [2];
  logic [2:0] rin [2];
  obs_t       obs [2];
  int         last_fs [2];
  int         last_ls [2];
  int         hs_run [2];
  int         vs_run [2];
  bit         fs_pend [2];
  int         fs_count_a = 0;

  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      abs_cyc++;
      if (rst) started = 1'b1;
      for (int d = 0; d < 2; d++) cyc[d] = rst ? 1 : cyc[d] + 1;
      @(negedge clk);
      if (started) begin
        obs[0] = {bus_a.pixel_tick, bus_a.coord_x, bus_a.coord_y, bus_a.active_area,
                  bus_a.line_start, bus_a.frame_start, hs_a, vs_a, rgb_a};
        obs[1] = {bus_b.pixel_tick, bus_b.coord_x, bus_b.coord_y, bus_b.active_area,
                  bus_b.line_start, bus_b.frame_start, hs_b, vs_b, rgb_b};
        rin[0] = bus_a.rgb_in;
        rin[1] = bus_b.rgb_in;
        for (int d = 0; d < 2; d++) begin
          e = model(cyc[d], CDV[d], SALV[d], cap[d]);
          check_obs(d, cyc[d], obs[d], e);

          if (cyc[d] == 1) begin
            last_fs[d] = -1;
            last_ls[d] = -1;
            hs_run[d]  = 0;
            vs_run[d]  = 0;
            fs_pend[d] = 1'b1;
          end
          if (obs[d].fs) begin
            if (fs_pend[d]) check_int("first_frame_start_cycle", d, cyc[d], FIRST_FS[d]);
            fs_pend[d] = 1'b0;
            if (last_fs[d] >= 0) check_int("frame_period", d, abs_cyc - last_fs[d], FRAME_LEN[d]);
            last_fs[d] = abs_cyc;
            if (d == 0) fs_count_a++;
          end
          if (obs[d].ls) begin
            if (last_ls[d] >= 0) check_int("line_period", d, abs_cyc - last_ls[d], LINE_LEN[d]);
            last_ls[d] = abs_cyc;
          end
          if (obs[d].hs != SALV[d]) hs_run[d]++;
          else if (hs_run[d] > 0) begin
            check_int("hsync_width", d, hs_run[d], HS_LEN[d]);
            hs_run[d] = 0;
          end
          if (obs[d].vs != SALV[d]) vs_run[d]++;
          else if (vs_run[d] > 0) begin
            check_int("vsync_width", d, vs_run[d], VS_LEN[d]);
            vs_run[d] = 0;
          end

          if ((cyc[d] % CDV[d]) == 0) cap[d] = rin[d];
        end
      end
    end
  end

  // sequence + final report
  initial begin
    bit hit;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // two frames of the divide-by-4 instance
    for (int n = 0; n < 30000 && fs_count_a < 2; n++) @(posedge clk);
    checks++;
    if (fs_count_a < 2) begin
      errors++;
      $display("FAIL wait_second_frame: got %0d frame_start pulses expected 2", fs_count_a);
    end

    // reset mid-frame at a known position
    hit = 1'b0;
    for (int n = 0; n < 30000 && !hit; n++) begin
      @(negedge clk);
      hit = (bus_a.coord_x == 10'd300) && (bus_a.coord_y == 10'd2);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_coord_300_2: got not reached expected reached");
    end
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // restart behaves like power-up, then one full frame period afterwards
    repeat (26000) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Video timing generator and pixel output stage for the snake display path. It divides the system clock down to a pixel rate and scans a 640x480@60 raster. It drives the coord_x/coord_y/active_area bus consumed by the graphics block, then registers that block's rgb back out aligned with hsync/vsync. It also provides a one-cycle frame_start pulse that game logic can use as a move timebase.

## Interface
- CLK_DIV, 4: clk cycles per pixel (100 MHz -> 25 MHz); legal 1..16
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal pixels; H_TOTAL = sum = 800
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical lines; V_TOTAL = sum = 525
- SYNC_ACTIVE_LOW, 1: 1 = syncs asserted low
- Constraint: H_TOTAL and V_TOTAL must each be ≤ 1024 (10-bit counters)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rgb_in  in  3  pixel colour from graphics, {R,G,B}
- pixel_tick  out  1  one-clk strobe per pixel period
- coord_x  out  10  current horizontal position, 0..H_TOTAL-1
- coord_y  out  10  current vertical position, 0..V_TOTAL-1
- active_area  out  1  coord inside H_ACTIVE x V_ACTIVE
- line_start  out  1  one-clk pulse when coord_x becomes 0
- frame_start  out  1  one-clk pulse when (coord_x,coord_y) becomes (0,0)
- hsync, vsync  out  1  to connector, aligned with rgb_out
- rgb_out  out  3  to DAC, blanked outside active area

## Operation
- Divider div counts 0..CLK_DIV-1 and wraps. pixel_tick = (div == CLK_DIV-1), decoded from the register. With CLK_DIV=1, pixel_tick is constantly 1 after reset.
- Internal position (h,v) advances on every clock where pixel_tick=1:
  - h increments; when h==H_TOTAL-1, h wraps to 0 and v increments.
  - When v==V_TOTAL-1 and h wraps, v wraps to 0.
- Stage A registers, updated only on pixel_tick edges from the post-advance (h,v):
  - coord_x=h, coord_y=v
  - active_area = (h<H_ACTIVE)&&(v<V_ACTIVE)
  - raw_hs = (h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC))
  - raw_vs = (v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC))
  - line_start and frame_start are set for exactly one clk when the new h==0 (and v==0 for frame_start).
- Stage B registers, updated on pixel_tick edges:
  - rgb_out <= active_area ? rgb_in : 3'b000 (uses the current stage-A value)
  - hsync <= raw_hs ^ SYNC_ACTIVE_LOW, vsync <= raw_vs ^ SYNC_ACTIVE_LOW
  - Net effect: the sync outputs lag coordinates by one pixel period, matching the rgb capture.
- rgb_in must be valid by the end of the pixel period in which its coord is presented. The graphics block therefore has CLK_DIV clk cycles, including any 1-cycle ROM latency.
- No handshake: the consumer is a pure follower of the coord bus.

## Timing
- Reset values: div=0, internal (h,v)=(H_TOTAL-1,V_TOTAL-1). Outputs: coord_x=0, coord_y=0, active_area=0, line_start=0, frame_start=0, rgb_out=0, hsync=vsync=inactive (1 when active-low).
- After reset deasserts, the first pixel_tick is the CLK_DIV-th cycle. The edge at the end of that cycle wraps (h,v) to (0,0), so frame_start and line_start pulse in the next cycle, with coord=(0,0) and active_area=1.
- Coord outputs are stable for exactly CLK_DIV clks. Pulses are 1 clk wide regardless of CLK_DIV.
- Period: line = H_TOTAL*CLK_DIV = 3200 clk; frame = V_TOTAL lines = 1,680,000 clk.
- hsync asserted for H_SYNC*CLK_DIV = 384 clk per line. vsync asserted for V_SYNC lines = 6400 clk, starting at the line-boundary tick of line 490 plus one pixel period.
- Reset mid-frame takes effect on the next edge, returns all outputs to reset values, and restarts the sequence exactly as from power-up.
- rgb_in changes mid-period do not reach rgb_out until the next pixel_tick edge.

## Test plan
- Reset release, default params -> pixel_tick first high in cycle 4. frame_start high in cycle 5 with coord=(0,0), active_area=1. Successive frame_start pulses exactly 1,680,000 clk apart.
- Line scan -> coord_x walks 0..799, each value held 4 clk. active_area=1 for coord_x 0..639, 0 for 640..799. line_start every 3200 clk.
- hsync measurement -> low for 384 clk per line, falling edge 1 pixel period after coord_x becomes 656. vsync low for 6400 clk, starting when coord_y becomes 490 (+1 pixel).
- Blanking: rgb_in held 3'b111 -> rgb_out=3'b111 only during the pixel period after an active coord, 3'b000 everywhere else. No colour in hsync or vsync periods.
- Reset asserted at coord=(300,200) for 3 clk -> next cycle all outputs at reset values. The frame_start pulse then follows the power-up timing (cycle 5 after release).
- CLK_DIV=1, SYNC_ACTIVE_LOW=0 -> pixel_tick constant 1, coord advances every clk, frame = 420,000 clk, hsync high for exactly 96 clk.
